// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg: opcodes, positive-ack value and FSM state type shared by cmd_seq.
package cmd_seq_pkg;
    localparam logic [7:0] STPTCH  = 8'h02;
    localparam logic [7:0] STRLL   = 8'h03;
    localparam logic [7:0] STYW    = 8'h04;
    localparam logic [7:0] STTHRST = 8'h05;
    localparam logic [7:0] CAL     = 8'h06;
    localparam logic [7:0] EMER    = 8'h07;
    localparam logic [7:0] MTSOFF  = 8'h08;
    localparam logic [7:0] ACK_VAL = 8'hA5;
    typedef enum logic [2:0] {IDLE, SEND, WAIT_SENT, WAIT_RESP, CHECK, FAIL} state_t;
endpackage

// File: rtl/cmd_seq_fifo.sv
// cmd_seq_fifo: DEPTH x W synchronous FIFO; full/empty registered from the next count.
module cmd_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic w_push, w_pop;
    assign w_push = i_push && !o_full;
    assign w_pop = i_pop && !o_empty;
    assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
    assign o_dout = r_mem[r_rd];
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= i_din;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
            r_cnt <= '0;
            o_full <= 1'b0;
            o_empty <= 1'b1;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= w_cnt_nxt;
            o_full <= w_cnt_nxt == CW'(DEPTH);
            o_empty <= w_cnt_nxt == '0;
        end
    end
endmodule

// File: rtl/cmd_seq.sv
// cmd_seq: queued command scheduler for RemoteComm with ack check, timeout and retry.
// Define CMD_SEQ_STATS_EN to add saturating ack_cnt/nak_cnt/tmo_cnt outputs.
module cmd_seq
    import cmd_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TMO_CYC = 100000,
    parameter int CAL_TMO_CYC = 1000000,
    parameter int MAX_RETRY = 2,
    parameter logic [7:0] ACK = ACK_VAL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  push_cmd,
    input  logic [15:0] push_data,
    output logic        full,
    output logic        empty,
    output logic        send_cmd,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        clr_resp_rdy,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_cmd
`ifdef CMD_SEQ_STATS_EN
    ,
    output logic [15:0] ack_cnt,
    output logic [15:0] nak_cnt,
    output logic [15:0] tmo_cnt
`endif
);
    localparam int TMAX = (TMO_CYC > CAL_TMO_CYC) ? TMO_CYC : CAL_TMO_CYC;
    localparam int TW = $clog2(TMAX + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    state_t r_state, w_next;
    logic [TW-1:0] r_tmr;
    logic [RW-1:0] r_retry;
    logic [7:0] r_cmd, r_err_cmd;
    logic [15:0] r_data;
    logic [23:0] w_head;
    logic w_pop, w_wait, w_tmo, w_last;
    cmd_seq_fifo #(.DEPTH(DEPTH), .W(24)) u_fifo (
        .clk(clk), .rst(rst), .i_push(push), .i_pop(w_pop), .i_din({push_cmd, push_data}),
        .o_dout(w_head), .o_full(full), .o_empty(empty)
    );
    assign w_wait = r_state == WAIT_SENT || r_state == WAIT_RESP;
    // A response always wins over a timeout expiring in the same cycle.
    assign w_tmo = w_wait && !resp_rdy && r_tmr == '0;
    assign w_last = r_retry >= RW'(MAX_RETRY);
    assign w_pop = r_state == IDLE && !resp_rdy && !empty;
    assign send_cmd = r_state == SEND;
    assign clr_resp_rdy = (r_state == IDLE && resp_rdy) || r_state == CHECK;
    assign done = r_state == CHECK && resp == ACK;
    assign err = r_state == FAIL && w_last;
    assign busy = r_state != IDLE;
    assign cmd = r_cmd;
    assign data = r_data;
    assign err_cmd = r_err_cmd;
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:      w_next = w_pop ? SEND : IDLE;
            SEND:      w_next = WAIT_SENT;
            WAIT_SENT: w_next = resp_rdy ? CHECK : w_tmo ? FAIL : cmd_sent ? WAIT_RESP : WAIT_SENT;
            WAIT_RESP: w_next = resp_rdy ? CHECK : w_tmo ? FAIL : WAIT_RESP;
            CHECK:     w_next = resp == ACK ? IDLE : FAIL;
            FAIL:      w_next = w_last ? IDLE : SEND;
            default:   w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr <= '0;
            r_retry <= '0;
            r_cmd <= '0;
            r_data <= '0;
            r_err_cmd <= '0;
        end else begin
            if (w_pop) begin
                {r_cmd, r_data} <= w_head;
                r_retry <= '0;
            end
            if (r_state == SEND) r_tmr <= (r_cmd == CAL) ? TW'(CAL_TMO_CYC) : TW'(TMO_CYC);
            else if (w_wait && r_tmr != '0) r_tmr <= r_tmr - 1'b1;
            if (r_state == FAIL && !w_last) r_retry <= r_retry + 1'b1;
            if (err) r_err_cmd <= r_cmd;
        end
    end
`ifdef CMD_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_cnt <= '0;
            nak_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (done && ack_cnt != 16'hFFFF) ack_cnt <= ack_cnt + 1'b1;
            if (r_state == CHECK && resp != ACK && nak_cnt != 16'hFFFF) nak_cnt <= nak_cnt + 1'b1;
            if (w_tmo && tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cmd_seq.sv
// tb_cmd_seq: directed and randomized checks of cmd_seq against a RemoteComm responder
// and an outcome model derived from the ack/timeout/retry rules.
module tb_cmd_seq;
    localparam int TMO = 1000;
    localparam int CAL_TMO = 5000;
    localparam int MAXR = 2;
    logic clk = 0, rst = 1, push = 0, cmd_sent = 0, resp_rdy = 0;
    logic [7:0] push_cmd = 0, resp = 0;
    logic [15:0] push_data = 0;
    logic full, empty, send_cmd, clr_resp_rdy, busy, done, err;
    logic [7:0] cmd, err_cmd;
    logic [15:0] data;
`ifdef CMD_SEQ_STATS_EN
    logic [15:0] ack_cnt, nak_cnt, tmo_cnt;
    logic [15:0] b_ack, b_nak, b_tmo;
`endif
    always #5 clk = ~clk;
    cmd_seq #(.DEPTH(4), .TMO_CYC(TMO), .CAL_TMO_CYC(CAL_TMO), .MAX_RETRY(MAXR), .ACK(8'hA5)) dut (
        .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd), .push_data(push_data),
        .full(full), .empty(empty), .send_cmd(send_cmd), .cmd(cmd), .data(data),
        .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp), .clr_resp_rdy(clr_resp_rdy),
        .busy(busy), .done(done), .err(err), .err_cmd(err_cmd)
`ifdef CMD_SEQ_STATS_EN
        , .ack_cnt(ack_cnt), .nak_cnt(nak_cnt), .tmo_cnt(tmo_cnt)
`endif
    );
    typedef struct {logic [7:0] v; int sd; int rd;} plan_t;
    plan_t plan_q[$];
    plan_t cur;
    int vec = 0, mis = 0, cyc = 0, n_send = 0, n_done = 0, n_err = 0, n_clr = 0;
    int phase = 0, cnt = 0;
    bit inj = 0;
    int send_cyc[$], done_cyc[$];
    logic [23:0] send_log[$], exp_send[$];
    logic [8:0] out_log[$], exp_out[$];
    // RemoteComm stand-in: per send_cmd, take the next plan, pulse cmd_sent after sd cycles and raise resp_rdy rd cycles later.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            phase = 0; resp_rdy = 0; cmd_sent = 0;
            continue;
        end
        if (send_cmd) begin n_send++; send_cyc.push_back(cyc); send_log.push_back({cmd, data}); end
        if (done) begin n_done++; done_cyc.push_back(cyc); out_log.push_back({1'b0, cmd}); end
        if (err) begin n_err++; out_log.push_back({1'b1, cmd}); end
        if (clr_resp_rdy) begin n_clr++; resp_rdy = 0; end
        cmd_sent = 0;
        if (inj) begin resp_rdy = 1; resp = 8'h3C; inj = 0; end
        if (send_cmd) begin
            if (plan_q.size() > 0) cur = plan_q.pop_front();
            else cur = '{v: 8'hA5, sd: 2, rd: 3};
            phase = 1; cnt = cur.sd;
        end else if (phase == 1) begin
            if (cnt == 0) begin cmd_sent = 1; phase = 2; cnt = cur.rd; end else cnt--;
        end else if (phase == 2) begin
            if (cnt == 0) begin resp_rdy = 1; resp = cur.v; phase = 0; end else cnt--;
        end
    end
    task automatic step(int n = 1);
        repeat (n) begin @(negedge clk); #1; end
    endtask
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic clear();
        n_send = 0; n_done = 0; n_err = 0; n_clr = 0;
        send_cyc.delete(); done_cyc.delete(); send_log.delete(); out_log.delete();
    endtask
    task automatic do_push(logic [7:0] c, logic [15:0] d);
        push = 1; push_cmd = c; push_data = d;
        step();
        push = 0;
    endtask
    task automatic wait_out(string tag, int target, int bound);
        int i = 0;
        while (n_done + n_err < target && i < bound) begin step(); i++; end
        chk({tag, "_outcome_wait"}, 32'(n_done + n_err >= target), 1);
    endtask
    task automatic wait_quiet(string tag, int bound);
        int i = 0;
        while (!(phase == 0 && !resp_rdy && !busy && empty) && i < bound) begin step(); i++; end
        chk({tag, "_quiet_wait"}, 32'(phase == 0 && !resp_rdy && !busy && empty), 1);
    endtask
    initial begin
        logic [7:0] op, v;
        logic [15:0] d;
        int t, w;
        bit ok;
        logic [7:0] t2_ops[5];
        t2_ops = '{8'h08, 8'h02, 8'h03, 8'h04, 8'h05};
        step(3);
        chk("rst_busy", busy, 0); chk("rst_empty", empty, 1); chk("rst_full", full, 0);
        chk("rst_send", send_cmd, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
        chk("rst_clr", clr_resp_rdy, 0); chk("rst_cmd", cmd, 0); chk("rst_data", data, 0);
        chk("rst_err_cmd", err_cmd, 0);
        rst = 0;
        step();
        // single command, latency and handshake
        clear();
        plan_q.push_back('{v: 8'hA5, sd: 300, rd: 50});
        do_push(8'h02, 16'hBEEF);
        chk("t1_no_send_yet", send_cmd, 0);
        step();
        chk("t1_send", send_cmd, 1); chk("t1_cmd", cmd, 8'h02); chk("t1_data", data, 16'hBEEF);
        wait_out("t1", 1, 1000);
        step();
        chk("t1_nsend", n_send, 1); chk("t1_ndone", n_done, 1); chk("t1_nerr", n_err, 0);
        chk("t1_nclr", n_clr, 1); chk("t1_busy", busy, 0); chk("t1_empty", empty, 1);
        // fill queue behind a long in-flight command, then push while full
        clear();
        plan_q.push_back('{v: 8'hA5, sd: 5, rd: 400});
        repeat (4) plan_q.push_back('{v: 8'hA5, sd: 3, rd: 10});
        do_push(8'h08, 16'h0000);
        step(3);
        do_push(8'h02, 16'hBEEF); do_push(8'h03, 16'h1F4B); do_push(8'h04, 16'h8DA0); do_push(8'h05, 16'h0045);
        chk("t2_full", full, 1);
        do_push(8'h07, 16'hDEAD);
        chk("t2_still_full", full, 1);
        wait_out("t2", 5, 3000);
        step(3);
        chk("t2_ndone", n_done, 5); chk("t2_nerr", n_err, 0); chk("t2_nsend", n_send, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), out_log[i], {1'b0, t2_ops[i]});
        chk("t2_data3", send_log[2], {8'h03, 16'h1F4B});
        for (int i = 0; i < 4; i++) chk($sformatf("t2_gap%0d", i), send_cyc[i+1] - done_cyc[i], 2);
        chk("t2_empty", empty, 1);
        // calibration gets the long timeout; other opcodes time out and retry
        clear();
        plan_q.push_back('{v: 8'hA5, sd: 5, rd: 3000});
        do_push(8'h06, 16'h0001);
        wait_out("t3cal", 1, 6000);
        chk("t3cal_nsend", n_send, 1); chk("t3cal_ndone", n_done, 1); chk("t3cal_nerr", n_err, 0);
        step();
        clear();
`ifdef CMD_SEQ_STATS_EN
        b_tmo = tmo_cnt;
`endif
        repeat (3) plan_q.push_back('{v: 8'hA5, sd: 5, rd: 3000});
        do_push(8'h07, 16'h0002);
        wait_out("t3tmo", 1, 6000);
        step();
        chk("t3tmo_nsend", n_send, 3); chk("t3tmo_nerr", n_err, 1); chk("t3tmo_ndone", n_done, 0);
        chk("t3tmo_err_cmd", err_cmd, 8'h07);
`ifdef CMD_SEQ_STATS_EN
        chk("t3tmo_tmo_cnt", tmo_cnt - b_tmo, 3);
`endif
        wait_quiet("t3", 5000);
        // two naks then an ack
        clear();
`ifdef CMD_SEQ_STATS_EN
        b_ack = ack_cnt; b_nak = nak_cnt;
`endif
        plan_q.push_back('{v: 8'hFF, sd: 2, rd: 3});
        plan_q.push_back('{v: 8'hFF, sd: 2, rd: 3});
        plan_q.push_back('{v: 8'hA5, sd: 2, rd: 3});
        do_push(8'h03, 16'h1234);
        wait_out("t4", 1, 1000);
        step();
        chk("t4_nsend", n_send, 3); chk("t4_ndone", n_done, 1); chk("t4_nerr", n_err, 0);
`ifdef CMD_SEQ_STATS_EN
        chk("t4_nak_cnt", nak_cnt - b_nak, 2); chk("t4_ack_cnt", ack_cnt - b_ack, 1);
`endif
        // unsolicited response while idle
        clear();
        inj = 1;
        step(4);
        chk("t5_nclr", n_clr, 1); chk("t5_ndone", n_done, 0); chk("t5_nerr", n_err, 0);
        chk("t5_busy", busy, 0); chk("t5_resp_rdy", resp_rdy, 0);
        // reset during WAIT_RESP with two entries queued
        clear();
        plan_q.push_back('{v: 8'hA5, sd: 5, rd: 500});
        do_push(8'h02, 16'h1111); do_push(8'h03, 16'h2222); do_push(8'h04, 16'h3333);
        step(40);
        chk("t6_busy_before", busy, 1); chk("t6_queued", empty, 0);
        rst = 1;
        step();
        chk("t6_busy_after", busy, 0); chk("t6_empty_after", empty, 1);
        rst = 0;
        plan_q.delete();
        step(600);
        chk("t6_no_done", n_done, 0); chk("t6_no_err", n_err, 0);
        clear();
        do_push(8'h05, 16'h0045);
        wait_out("t6_new", 1, 1000);
        chk("t6_new_out", out_log[0], {1'b0, 8'h05});
        // randomized commands against the retry/timeout outcome model
        wait_quiet("rnd_pre", 2000);
        clear();
        plan_q.delete(); exp_send.delete(); exp_out.delete();
        for (int i = 0; i < 8; i++) begin
            op = 8'($urandom_range(2, 8));
            d = 16'($urandom);
            t = (op == 8'h06) ? CAL_TMO : TMO;
            ok = 0;
            for (int a = 0; a <= MAXR && !ok; a++) begin
                plan_t p;
                case ($urandom_range(0, 3))
                    0: begin
                        v = 8'($urandom_range(0, 255));
                        if (v == 8'hA5) v = 8'h00;
                        p = '{v: v, sd: 2, rd: 2};
                    end
                    1: p = '{v: 8'hA5, sd: 5, rd: 1500};
                    default: p = '{v: 8'hA5, sd: int'($urandom_range(0, 20)), rd: int'($urandom_range(0, 100))};
                endcase
                plan_q.push_back(p);
                exp_send.push_back({op, d});
                ok = p.v == 8'hA5 && p.sd + p.rd + 10 < t;
            end
            exp_out.push_back({!ok, op});
            w = 0;
            while (full && w < 6000) begin step(); w++; end
            chk($sformatf("rnd_full_wait%0d", i), full, 0);
            do_push(op, d);
        end
        wait_out("rnd", 8, 40000);
        chk("rnd_nsend", send_log.size(), exp_send.size());
        chk("rnd_nout", out_log.size(), exp_out.size());
        foreach (exp_send[i]) chk($sformatf("rnd_send%0d", i), send_log[i], exp_send[i]);
        foreach (exp_out[i]) chk($sformatf("rnd_out%0d", i), out_log[i], exp_out[i]);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
